// File: rtl/spi_daisy_chain.sv
// spi_daisy_chain: one SPI master and two SPI slaves in a ring (mosi -> s1 -> s2 -> miso).
// Latency: (2*DATA_WIDTH+2)*HALF+1 clk from the start sample to spi_m_done; slave done pulses 2 clk later.
// Backpressure: none; spi_m_start is ignored while the master is busy. Define SPI_LSB_FIRST_EN for LSB-first shifting.
// Requires HALF = CLK_FREQ/(2*SPI_FREQ) >= 3 and DATA_WIDTH >= 2 so slave edge detection settles before the next master edge.

module spi_daisy_master #(
    parameter int DATA_WIDTH = 8,
    parameter int HALF       = 5,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] send,
    input  logic                  miso,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] recv,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi
);
    localparam int CW = $clog2(HALF);
    localparam int EW = $clog2(2 * DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         half_cnt;
    logic [EW-1:0]         edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_nxt;
    logic                  half_end, clk_edge, lead_edge, sample_edge, shift_edge;
    logic                  last_edge, last_sample;

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
        if (LSB_FIRST) return v >> 1;
        else           return v << 1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
        if (LSB_FIRST) return (v >> 1) | (DATA_WIDTH'(b) << (DATA_WIDTH - 1));
        else           return (v << 1) | DATA_WIDTH'(b);
    endfunction

    assign half_end    = (half_cnt == CW'(HALF - 1));
    assign clk_edge    = (state == XFER) && half_end;
    // even edge index = leading edge (away from idle level)
    assign lead_edge   = ~edge_cnt[0];
    assign sample_edge = clk_edge && (lead_edge ^ CPHA);
    // with CPHA=1 the first leading edge only presents the first bit, it must not discard it
    assign shift_edge  = clk_edge && !(lead_edge ^ CPHA) && !(CPHA && (edge_cnt == '0));
    assign last_edge   = (edge_cnt == EW'(2 * DATA_WIDTH - 1));
    assign last_sample = (edge_cnt[EW-1:1] == (EW - 1)'(DATA_WIDTH - 1));
    assign rx_nxt      = shift_in(rx_sr, miso);

    // State register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (half_end) state_nxt = XFER;
            XFER:    if (half_end && last_edge) state_nxt = HOLD;
            HOLD:    if (half_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: chip select, done pulse and the current output bit
    always_comb begin
        cs_n = 1'b1;
        done = 1'b0;
        mosi = 1'b0;
        case (state)
            SETUP, XFER, HOLD: begin
                cs_n = 1'b0;
                mosi = LSB_FIRST ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Half-period timer, edge counter and SCLK generation
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            sclk     <= CPOL;
        end else begin
            if (state == IDLE || state == DONE || half_end) half_cnt <= '0;
            else                                            half_cnt <= half_cnt + CW'(1);

            if (state != XFER) edge_cnt <= '0;
            else if (half_end) edge_cnt <= edge_cnt + EW'(1);

            if (clk_edge)           sclk <= ~sclk;
            else if (state != XFER) sclk <= CPOL;
        end
    end

    // Shift registers: load on start, shift/sample on the SCLK edges, publish the word on the last sample
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_sr <= '0;
            rx_sr <= '0;
            recv  <= '0;
        end else begin
            if (state == IDLE && start) tx_sr <= send;
            else if (shift_edge)        tx_sr <= shift_out(tx_sr);

            if (sample_edge) begin
                rx_sr <= rx_nxt;
                if (last_sample) recv <= rx_nxt;
            end
        end
    end
endmodule

module spi_daisy_slave #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  din,
    input  logic [DATA_WIDTH-1:0] send,
    output logic                  dout,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] recv
);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic                  sclk_q, sclk_qq, cs_q, cs_qq;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_nxt;
    logic [BW-1:0]         bit_cnt;
    logic                  first, active;
    logic                  lead, trail, cs_fall, cs_rise, sample_edge, shift_kind, shift_edge;

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
        if (LSB_FIRST) return v >> 1;
        else           return v << 1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
        if (LSB_FIRST) return (v >> 1) | (DATA_WIDTH'(b) << (DATA_WIDTH - 1));
        else           return (v << 1) | DATA_WIDTH'(b);
    endfunction

    assign lead        = (sclk_q != CPOL) && (sclk_qq == CPOL);
    assign trail       = (sclk_q == CPOL) && (sclk_qq != CPOL);
    assign cs_fall     = !cs_q && cs_qq;
    assign cs_rise     = cs_q && !cs_qq;
    assign sample_edge = !cs_q && (CPHA ? trail : lead);
    assign shift_kind  = !cs_q && (CPHA ? lead : trail);
    assign shift_edge  = shift_kind && !(CPHA && first);
    assign rx_nxt      = shift_in(rx_sr, din);
    assign dout        = active ? (LSB_FIRST ? tx_sr[0] : tx_sr[DATA_WIDTH-1]) : 1'b0;

    // Register SCLK and CS_n once and keep the previous sample for edge detection
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sclk_q  <= CPOL;
            sclk_qq <= CPOL;
            cs_q    <= 1'b1;
            cs_qq   <= 1'b1;
        end else begin
            sclk_q  <= sclk;
            sclk_qq <= sclk_q;
            cs_q    <= cs_n;
            cs_qq   <= cs_q;
        end
    end

    // Frame handling: load on CS fall, sample/shift on detected edges, done on CS rise after a full word
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            first   <= 1'b0;
            active  <= 1'b0;
            recv    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cs_fall) begin
                tx_sr   <= send;
                bit_cnt <= '0;
                first   <= 1'b1;
                active  <= 1'b1;
            end else if (cs_rise) begin
                active <= 1'b0;
                done   <= (bit_cnt == BW'(DATA_WIDTH));
            end else begin
                if (sample_edge) begin
                    rx_sr <= rx_nxt;
                    if (bit_cnt != BW'(DATA_WIDTH)) bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) recv <= rx_nxt;
                end
                if (shift_kind) first <= 1'b0;
                if (shift_edge) tx_sr <= shift_out(tx_sr);
            end
        end
    end
endmodule

module spi_daisy_chain #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 5_000_000,
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  spi_m_start,
    input  logic [DATA_WIDTH-1:0] data_m_send,
    output logic                  spi_m_done,
    output logic [DATA_WIDTH-1:0] data_m_recv,
    input  logic [DATA_WIDTH-1:0] data_s1_send,
    output logic                  spi_s1_done,
    output logic [DATA_WIDTH-1:0] data_s1_recv,
    input  logic [DATA_WIDTH-1:0] data_s2_send,
    output logic                  spi_s2_done,
    output logic [DATA_WIDTH-1:0] data_s2_recv
);
    localparam int HALF = CLK_FREQ / (2 * SPI_FREQ);
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic sclk, cs_n, mosi, miso_s1, miso_s2;

    spi_daisy_master #(
        .DATA_WIDTH(DATA_WIDTH), .HALF(HALF), .CPOL(CPOL), .CPHA(CPHA), .LSB_FIRST(LSB_FIRST)
    ) u_master (
        .clk(clk), .arstn(arstn), .start(spi_m_start), .send(data_m_send), .miso(miso_s2),
        .done(spi_m_done), .recv(data_m_recv), .sclk(sclk), .cs_n(cs_n), .mosi(mosi)
    );

    spi_daisy_slave #(
        .DATA_WIDTH(DATA_WIDTH), .CPOL(CPOL), .CPHA(CPHA), .LSB_FIRST(LSB_FIRST)
    ) u_s1 (
        .clk(clk), .arstn(arstn), .sclk(sclk), .cs_n(cs_n), .din(mosi), .send(data_s1_send),
        .dout(miso_s1), .done(spi_s1_done), .recv(data_s1_recv)
    );

    spi_daisy_slave #(
        .DATA_WIDTH(DATA_WIDTH), .CPOL(CPOL), .CPHA(CPHA), .LSB_FIRST(LSB_FIRST)
    ) u_s2 (
        .clk(clk), .arstn(arstn), .sclk(sclk), .cs_n(cs_n), .din(miso_s1), .send(data_s2_send),
        .dout(miso_s2), .done(spi_s2_done), .recv(data_s2_recv)
    );
endmodule

// File: tb/tb_spi_daisy_chain.sv
// Bench for spi_daisy_chain: four instances (SPI modes 0..3) share one stimulus stream.
// Reference model: the ring rotates words, node k receives the word sent by its upstream node.
// Node 0 = master, 1 = slave 1, 2 = slave 2; upstream of node k is node (k+2)%3.
module tb_spi_daisy_chain;
    localparam int DW   = 8;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic arstn, start;
    logic [DW-1:0] m_send, s1_send, s2_send;
    logic [3:0] m_done, s1_done, s2_done;
    logic [3:0][DW-1:0] m_recv, s1_recv, s2_recv;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_daisy_chain #(
            .CLK_FREQ(50_000_000), .SPI_FREQ(5_000_000), .DATA_WIDTH(DW),
            .CPOL(g >= 2), .CPHA((g % 2) == 1)
        ) dut (
            .clk(clk), .arstn(arstn), .spi_m_start(start), .data_m_send(m_send),
            .spi_m_done(m_done[g]), .data_m_recv(m_recv[g]),
            .data_s1_send(s1_send), .spi_s1_done(s1_done[g]), .data_s1_recv(s1_recv[g]),
            .data_s2_send(s2_send), .spi_s2_done(s2_done[g]), .data_s2_recv(s2_recv[g])
        );
    end

    wire cs0   = g_dut[0].dut.cs_n;
    wire sclk0 = g_dut[0].dut.sclk;
    wire sclk2 = g_dut[2].dut.sclk;

    // model state
    logic [DW-1:0] sent [3];
    function automatic logic [DW-1:0] expect_recv(input int node);
        return sent[(node + 2) % 3];
    endfunction

    // monitor (negedge) -- running totals, never reset
    int cyc = 0, cs_low_tot = 0, tog_tot = 0, rise_prev = 0, rise_last = 0;
    int t_start = 0, t_mdone = 0, t_s1done = 0;
    int md_tot [4], s1d_tot [4], s2d_tot [4];
    logic [DW-1:0] cap_s1 [4], cap_s2 [4], cap_m [4];
    bit busy = 1'b0;
    logic sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!arstn) busy = 1'b0;
        if (m_done[0]) begin busy = 1'b0; t_mdone = cyc; end
        if (arstn && start && !busy) begin busy = 1'b1; t_start = cyc; end
        if (s1_done[0]) t_s1done = cyc;
        if (!cs0) cs_low_tot++;
        if (sclk0 !== sclk_prev) begin
            tog_tot++;
            if (sclk0) begin rise_prev = rise_last; rise_last = cyc; end
        end
        sclk_prev = sclk0;
        for (int i = 0; i < 4; i++) begin
            if (m_done[i])  begin md_tot[i]++; cap_s1[i] = s1_recv[i]; cap_s2[i] = s2_recv[i]; end
            if (s1_done[i]) begin s1d_tot[i]++; cap_m[i] = m_recv[i]; end
            if (s2_done[i]) s2d_tot[i]++;
        end
        cyc++;
    end

    // snapshots taken at transfer start
    int md_s [4], s1d_s [4], s2d_s [4];
    int cs_s = 0, tog_s = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take_done_snapshot();
        for (int i = 0; i < 4; i++) begin
            md_s[i] = md_tot[i]; s1d_s[i] = s1d_tot[i]; s2d_s[i] = s2d_tot[i];
        end
    endtask

    task automatic do_start(input logic [DW-1:0] m, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
        sent[0] = m; sent[1] = s1; sent[2] = s2;
        m_send = m; s1_send = s1; s2_send = s2;
        cs_s = cs_low_tot; tog_s = tog_tot;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        // send words must be ignored once the transfer has begun
        m_send = DW'($urandom); s1_send = DW'($urandom); s2_send = DW'($urandom);
        take_done_snapshot();
    endtask

    task automatic wait_mdone(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_done[0]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic finish_xfer(input string tag, input bit full, input bit timing);
        bit ok;
        wait_mdone(ok);
        chk({tag, " done_seen"}, 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s d%0d m_recv", tag, i),  32'(m_recv[i]),  32'(expect_recv(0)));
            chk($sformatf("%s d%0d s1_recv", tag, i), 32'(s1_recv[i]), 32'(expect_recv(1)));
            chk($sformatf("%s d%0d s2_recv", tag, i), 32'(s2_recv[i]), 32'(expect_recv(2)));
        end
        step(1);
        if (full) begin
            step(4);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s d%0d m_done_cnt", tag, i),  32'(md_tot[i] - md_s[i]), 32'd1);
                chk($sformatf("%s d%0d s1_done_cnt", tag, i), 32'(s1d_tot[i] - s1d_s[i]), 32'd1);
                chk($sformatf("%s d%0d s2_done_cnt", tag, i), 32'(s2d_tot[i] - s2d_s[i]), 32'd1);
                chk($sformatf("%s d%0d s1_before_mdone", tag, i), 32'(cap_s1[i]), 32'(expect_recv(1)));
                chk($sformatf("%s d%0d s2_before_mdone", tag, i), 32'(cap_s2[i]), 32'(expect_recv(2)));
                chk($sformatf("%s d%0d m_before_sdone", tag, i),  32'(cap_m[i]),  32'(expect_recv(0)));
            end
        end
        if (timing) begin
            chk({tag, " cs_low_cycles"}, 32'(cs_low_tot - cs_s), 32'((2 * DW + 2) * HALF));
            chk({tag, " sclk_edges"}, 32'(tog_tot - tog_s), 32'(2 * DW));
            chk({tag, " sclk_period"}, 32'(rise_last - rise_prev), 32'(2 * HALF));
            chk({tag, " start_to_done"}, 32'(t_mdone - t_start), 32'((2 * DW + 2) * HALF + 1));
            if (full)
                chk({tag, " sdone_lag_1_2"}, 32'((t_s1done - t_mdone >= 1) && (t_s1done - t_mdone <= 2)), 32'd1);
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s d%0d m_recv", tag, i),  32'(m_recv[i]),  32'd0);
            chk($sformatf("%s d%0d s1_recv", tag, i), 32'(s1_recv[i]), 32'd0);
            chk($sformatf("%s d%0d s2_recv", tag, i), 32'(s2_recv[i]), 32'd0);
            chk($sformatf("%s d%0d dones", tag, i), 32'({m_done[i], s1_done[i], s2_done[i]}), 32'd0);
        end
        chk({tag, " cs_n"}, 32'(cs0), 32'd1);
        chk({tag, " sclk_cpol0"}, 32'(sclk0), 32'd0);
        chk({tag, " sclk_cpol1"}, 32'(sclk2), 32'd1);
    endtask

    int md_keep;

    initial begin
        arstn = 1'b0; start = 1'b0;
        m_send = '0; s1_send = '0; s2_send = '0;
        step(3);
        check_cleared("reset");
        arstn = 1'b1;
        step(2);

        // directed transfer with timing measurement
        do_start(8'hAB, 8'hCD, 8'hEF);
        finish_xfer("basic", 1'b1, 1'b1);

        // back-to-back: second start the cycle after DONE
        do_start(8'h5A, 8'h3C, 8'hC3);
        finish_xfer("b2b_a", 1'b0, 1'b0);
        do_start(8'hEE, 8'hFF, 8'hAA);
        finish_xfer("b2b_b", 1'b1, 1'b1);

        // edge patterns
        do_start(8'h01, 8'h80, 8'h00);
        finish_xfer("edge", 1'b1, 1'b0);

        // start pulse during XFER must be ignored
        do_start(DW'($urandom), DW'($urandom), DW'($urandom));
        step(36);
        start = 1'b1;
        step(1);
        start = 1'b0;
        finish_xfer("mid_start", 1'b1, 1'b1);
        md_keep = md_tot[0];
        step(120);
        chk("mid_start no_extra_xfer", 32'(md_tot[0] - md_keep), 32'd0);
        chk("mid_start held m_recv", 32'(m_recv[0]), 32'(expect_recv(0)));

        // random transfers
        for (int k = 0; k < 4; k++) begin
            do_start(DW'($urandom), DW'($urandom), DW'($urandom));
            finish_xfer($sformatf("rand%0d", k), 1'b1, 1'b0);
        end

        // reset mid-XFER aborts with no done pulse
        do_start(DW'($urandom), DW'($urandom), DW'($urandom));
        step(36);
        arstn = 1'b0;
        step(2);
        check_cleared("mid_reset");
        arstn = 1'b1;
        step(150);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid_reset d%0d no_done", i),
                32'((md_tot[i] - md_s[i]) + (s1d_tot[i] - s1d_s[i]) + (s2d_tot[i] - s2d_s[i])), 32'd0);
        end
        do_start(DW'($urandom), DW'($urandom), DW'($urandom));
        finish_xfer("after_reset", 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
